// File: rtl/ms_dff_reg_arbiter.sv
// rtl/ms_dff_reg_arbiter.sv - round-robin write arbiter for a shared master-slave D register
//
// Purpose:
//   NREQ requesters share one DATA_W-bit register. A write request is granted in
//   IDLE, its data is latched at the grant edge, the register is loaded during
//   LOAD, and the winner receives a one-cycle ack in ACK. One write completes
//   every three cycles at most.
//
// Ports:
//   clk      in   1            clock, rising edge
//   rst_n    in   1            synchronous reset, active low
//   req      in   NREQ         level write request per requester, held until ack
//   wr_data  in   NREQ*DATA_W  write data, requester i on [i*DATA_W +: DATA_W]
//   ack      out  NREQ         one-cycle write-complete pulse to the winner
//   gnt_id   out  IDX_W        index of the current or last winner
//   busy     out  1            high in LOAD and ACK
//   q        out  DATA_W       shared register value
//   qn       out  DATA_W       complement of q
//
// Configuration:
//   MSREG_FIXED_PRIO_EN  defined: lowest asserted index always wins (no last pointer)
//                        undefined: round-robin starting after the last winner

module ms_dff_reg_arbiter #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 8,
  parameter int IDX_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DATA_W-1:0] wr_data,
  output logic [NREQ-1:0]        ack,
  output logic [IDX_W-1:0]       gnt_id,
  output logic                   busy,
  output logic [DATA_W-1:0]      q,
  output logic [DATA_W-1:0]      qn
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic              grant_en;
  logic              load_en;
  logic              ack_en;
  logic              req_any;
  logic [IDX_W-1:0]  pick;
  logic [IDX_W-1:0]  win;
  logic [IDX_W-1:0]  scan_base;
  logic [DATA_W-1:0] data_lat;
  logic [DATA_W-1:0] slices [NREQ];

  // Unpack the flat write-data bus so the winner can be selected by index.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign slices[gi] = wr_data[gi*DATA_W +: DATA_W];
  end

  assign req_any = |req;

`ifdef MSREG_FIXED_PRIO_EN
  // Scanning from (NREQ-1)+1 wraps to index 0, so the lowest set bit wins.
  assign scan_base = IDX_W'(NREQ - 1);
`else
  logic [IDX_W-1:0] last;

  // Last-winner pointer; reset to NREQ-1 so requester 0 is first in line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last <= IDX_W'(NREQ - 1);
    end else if (ack_en) begin
      last <= win;
    end
  end

  assign scan_base = last;
`endif

  // Winner: first set request bit scanning upward from scan_base+1 with wrap.
  always_comb begin
    logic             found;
    int               sum;
    logic [IDX_W-1:0] idx;
    pick  = '0;
    found = 1'b0;
    sum   = 0;
    idx   = '0;
    for (int off = 1; off <= NREQ; off++) begin
      sum = (int'(scan_base) + off) % NREQ;
      idx = sum[IDX_W-1:0];
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and per-state strobes.
  always_comb begin
    state_nxt = state;
    grant_en  = 1'b0;
    load_en   = 1'b0;
    ack_en    = 1'b0;
    case (state)
      IDLE: begin
        if (req_any) begin
          grant_en  = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        load_en   = 1'b1;
        state_nxt = ACK;
      end
      ACK: begin
        // A request still high here waits for IDLE, where it is re-arbitrated.
        ack_en    = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Grant capture: winner index and its data are frozen at the grant edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win      <= '0;
      gnt_id   <= '0;
      data_lat <= '0;
    end else if (grant_en) begin
      win      <= pick;
      gnt_id   <= pick;
      data_lat <= slices[pick];
    end
  end

  // Shared register bank; qn is stored as its own complementary output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q  <= '0;
      qn <= '1;
    end else if (load_en) begin
      q  <= data_lat;
      qn <= ~data_lat;
    end
  end

  assign busy = (state != IDLE);
  assign ack  = ack_en ? (NREQ'(1) << win) : '0;

endmodule
